// File: rtl/lcd_frame_arbiter_if.sv
// lcd_frame_arbiter_if
//   Bundles the signals between the pixel sources / LCD timing block and the
//   frame arbiter.
//   master modport : source side (timing, requests, pixel data in; panel
//                    colour, grant and switch pulse back)
//   slave modport  : arbiter side
//   vd         vertical sync, active-low pulse
//   den        data enable
//   req        level request per source, bit i = source i
//   force_next one-cycle pulse, rotate at the next frame boundary
//   src_rgb    packed {R,G,B} per source, source i at [3*CW*i +: 3*CW]
//   r, g, b    registered panel colour
//   gnt        one-hot current owner, zero when idle
//   switched   one-cycle pulse in the cycle gnt changes
interface lcd_frame_arbiter_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned CW    = 8
);
    logic                    vd;
    logic                    den;
    logic [N_SRC-1:0]        req;
    logic                    force_next;
    logic [N_SRC*3*CW-1:0]   src_rgb;
    logic [CW-1:0]           r;
    logic [CW-1:0]           g;
    logic [CW-1:0]           b;
    logic [N_SRC-1:0]        gnt;
    logic                    switched;

    modport master (
        output vd, den, req, force_next, src_rgb,
        input  r, g, b, gnt, switched
    );

    modport slave (
        input  vd, den, req, force_next, src_rgb,
        output r, g, b, gnt, switched
    );
endinterface

// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter
//   Shares one LCD panel between N_SRC pixel generators. Ownership only moves
//   at a frame boundary (falling edge of vd), so a frame is never split between
//   two sources. Owners are chosen round-robin, keep the panel for at least
//   DWELL_FRAMES before an automatic rotation, rotate after AUTO_FRAMES when
//   someone else is waiting (0 disables), and can be moved on with force_next.
// Ports
//   clk    pixel clock, same clock as the sync generator
//   rst_n  asynchronous active-low reset
//   bus    lcd_frame_arbiter_if.slave: vd, den, req, force_next, src_rgb in;
//          r, g, b, gnt, switched out
module lcd_frame_arbiter #(
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned DWELL_FRAMES = 2,
    parameter int unsigned AUTO_FRAMES  = 120,
    parameter int unsigned CW           = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_frame_arbiter_if.slave   bus
);

    localparam int unsigned IW = $clog2(N_SRC);
    localparam int unsigned PW = 3 * CW;

    localparam logic [IW:0]   NS       = (IW+1)'(N_SRC);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SRC - 1);
    localparam logic [15:0]   FCNT_MAX = 16'hFFFF;
    localparam logic [15:0]   AUTO_F   = 16'(AUTO_FRAMES);
    localparam logic [15:0]   DWELL_F  = 16'(DWELL_FRAMES);
    localparam bit            AUTO_ON  = (AUTO_FRAMES != 0);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             vd_q;
    logic             frame_tick;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [15:0]      fcnt_inc;
    logic             force_pend_q, force_pend_d;
    logic             force_now;
    logic             switched_q, switched_d;
    logic [PW-1:0]    rgb_q, rgb_d;

    logic             idle_found;
    logic [IW-1:0]    idle_idx;
    logic             next_found;
    logic [IW-1:0]    next_idx;
    logic             do_grant;
    logic [IW-1:0]    grant_idx;

    // vd_q resets low, so a tick needs vd sampled high first.
    assign frame_tick = vd_q & ~bus.vd;

    // Round-robin searches. The loops run from the farthest candidate to the
    // nearest so the nearest requester is the last (winning) assignment.
    always_comb begin
        logic [IW:0] p;
        p          = '0;
        idle_found = 1'b0;
        idle_idx   = '0;
        next_found = 1'b0;
        next_idx   = '0;
        // From rr_ptr upward, owner excluded trivially (there is none).
        for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
            p = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (p >= NS) p = p - NS;
            if (bus.req[p[IW-1:0]]) begin
                idle_found = 1'b1;
                idle_idx   = p[IW-1:0];
            end
        end
        // From owner+1 upward with wrap; k never reaches 0 so the owner is excluded.
        for (int k = int'(N_SRC) - 1; k >= 1; k--) begin
            p = {1'b0, owner_q} + (IW+1)'(k);
            if (p >= NS) p = p - NS;
            if (bus.req[p[IW-1:0]]) begin
                next_found = 1'b1;
                next_idx   = p[IW-1:0];
            end
        end
    end

    assign fcnt_inc  = (fcnt_q == FCNT_MAX) ? fcnt_q : fcnt_q + 16'd1;
    // A force_next coinciding with the tick counts as already pending.
    assign force_now = force_pend_q | bus.force_next;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        fcnt_d       = fcnt_q;
        switched_d   = 1'b0;
        force_pend_d = force_now;
        do_grant     = 1'b0;
        grant_idx    = '0;

        if (frame_tick) begin
            // Every tick consumes a pending force, whatever it decided.
            force_pend_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (idle_found) begin
                        do_grant  = 1'b1;
                        grant_idx = idle_idx;
                    end
                end
                OWN: begin
                    fcnt_d = fcnt_inc;
                    if (!bus.req[owner_q]) begin
                        // Owner walked away: leave immediately, dwell ignored.
                        if (next_found) begin
                            do_grant  = 1'b1;
                            grant_idx = next_idx;
                        end else begin
                            state_d    = IDLE;
                            gnt_d      = '0;
                            fcnt_d     = '0;
                            switched_d = 1'b1;
                        end
                    end else if (force_now) begin
                        if (next_found) begin
                            do_grant  = 1'b1;
                            grant_idx = next_idx;
                        end else begin
                            // Nobody to hand over to: restart the owner's frame count.
                            fcnt_d = '0;
                        end
                    end else if (AUTO_ON && fcnt_inc >= AUTO_F && fcnt_inc >= DWELL_F
                                 && next_found) begin
                        do_grant  = 1'b1;
                        grant_idx = next_idx;
                    end
                end
                default: ;
            endcase
        end

        if (do_grant) begin
            state_d         = OWN;
            owner_d         = grant_idx;
            gnt_d           = '0;
            gnt_d[grant_idx] = 1'b1;
            rr_ptr_d        = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
            fcnt_d          = '0;
            switched_d      = 1'b1;
        end
    end

    // Pixel path: one register stage, black outside den or while idle.
    always_comb begin
        rgb_d = '0;
        if (bus.den && (gnt_q != '0)) begin
            rgb_d = bus.src_rgb[int'(owner_q)*PW +: PW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vd_q         <= 1'b0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            fcnt_q       <= '0;
            force_pend_q <= 1'b0;
            switched_q   <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            vd_q         <= bus.vd;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            fcnt_q       <= fcnt_d;
            force_pend_q <= force_pend_d;
            switched_q   <= switched_d;
            rgb_q        <= rgb_d;
        end
    end

    assign bus.r        = rgb_q[2*CW +: CW];
    assign bus.g        = rgb_q[CW +: CW];
    assign bus.b        = rgb_q[0 +: CW];
    assign bus.gnt      = gnt_q;
    assign bus.switched = switched_q;

    // Internal consistency: grant is one-hot or empty, matches owner and state.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_gnt_owner: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_q != '0) |-> gnt_q[owner_q]);
    a_state_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == OWN) == (gnt_q != '0));

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
module tb_lcd_frame_arbiter;

    localparam int N     = 4;
    localparam int CW    = 8;
    localparam int PW    = 3 * CW;
    localparam int DWELL = 2;
    localparam int AUTO  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    lcd_frame_arbiter_if #(.N_SRC(N), .CW(CW)) bus ();

    lcd_frame_arbiter #(
        .N_SRC       (N),
        .DWELL_FRAMES(DWELL),
        .AUTO_FRAMES (AUTO),
        .CW          (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = idle), round-robin start, frames owned.
    int m_owner;
    int m_rr;
    int m_fcnt;
    bit m_fpend;
    bit m_sw;

    // What was presented to the DUT before the latest clock edge.
    bit            l_den;
    int            l_owner;
    logic [PW-1:0] l_src [N];

    int pix_bad;
    int sw_bad;

    function automatic logic [3:0] oh(input int o);
        logic [3:0] v;
        v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] exp_pix();
        if (l_den && l_owner >= 0) return l_src[l_owner];
        return '0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_rr    = 0;
        m_fcnt  = 0;
        m_fpend = 1'b0;
        m_sw    = 1'b0;
        l_owner = -1;
    endtask

    // Decision taken at one frame boundary, straight from the arbitration rules.
    task automatic model_tick(input logic [3:0] rq, input bit frc);
        int prev;
        int nxt;
        prev = m_owner;
        nxt  = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (rq[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    break;
                end
            end
        end else begin
            if (m_fcnt < 65535) m_fcnt = m_fcnt + 1;
            for (int k = 1; k < N; k++) begin
                if (rq[(m_owner + k) % N]) begin
                    nxt = (m_owner + k) % N;
                    break;
                end
            end
            if (!rq[m_owner]) m_owner = nxt;
            else if (frc) begin
                if (nxt >= 0) m_owner = nxt;
                else m_fcnt = 0;
            end else if (AUTO != 0 && m_fcnt >= AUTO && m_fcnt >= DWELL && nxt >= 0)
                m_owner = nxt;
        end
        m_sw = (m_owner != prev);
        if (m_sw) begin
            m_fcnt = 0;
            if (m_owner >= 0) m_rr = (m_owner + 1) % N;
        end
        m_fpend = 1'b0;
    endtask

    // One clock: drive at the falling edge, return 1 ns after the rising edge.
    task automatic cycle(input bit vd_v, input bit den_v, input bit fn);
        logic [N*PW-1:0] v;
        @(negedge clk);
        bus.vd         = vd_v;
        bus.den        = den_v;
        bus.force_next = fn;
        for (int i = 0; i < N; i++) begin
            l_src[i]      = PW'($urandom);
            v[PW*i +: PW] = l_src[i];
        end
        bus.src_rgb = v;
        l_den       = den_v;
        l_owner     = m_owner;
        @(posedge clk);
        #1;
    endtask

    // One frame: blanking, active video, blanking, then a one-cycle vd low
    // (the frame boundary). req settles to req_tick mid-frame; with glitch it
    // wanders randomly before that. frc: 0 none, 1 pulse mid-frame, 2 on the tick.
    task automatic frame(input logic [3:0] req_tick, input int frc, input bit glitch);
        for (int c = 0; c < 10; c++) begin
            bit den_v;
            bit fn;
            den_v = (c >= 2 && c < 8);
            fn    = (frc == 1 && c == 3);
            if (c < 5 && glitch) bus.req = 4'($urandom);
            else if (c >= 5) bus.req = req_tick;
            if (fn) m_fpend = 1'b1;
            cycle(1'b1, den_v, fn);
            if ({bus.r, bus.g, bus.b} !== exp_pix()) pix_bad++;
            if (bus.switched !== 1'b0) sw_bad++;
        end
        bus.req = req_tick;
        cycle(1'b0, 1'b0, frc == 2);
        model_tick(req_tick, m_fpend || frc == 2);
        if ({bus.r, bus.g, bus.b} !== exp_pix()) pix_bad++;
        bus.force_next = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        bus.vd         = 1'b1;
        bus.den        = 1'b0;
        bus.req        = '0;
        bus.force_next = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            n_checks++;
            if (bus.gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_gnt: got %b required 0000", bus.gnt);
            end
            n_checks++;
            if ({bus.r, bus.g, bus.b} !== 24'h0) begin
                n_fail++;
                $display("FAIL reset_rgb: got %h required 000000", {bus.r, bus.g, bus.b});
            end
            n_checks++;
            if (bus.switched !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_switched: got %b required 0", bus.switched);
            end
        end
        @(negedge clk);
        bus.den = 1'b0;
        rst_n   = 1'b1;
        model_reset();
    endtask

    task automatic test_single_source();
        pix_bad = 0;
        sw_bad  = 0;
        for (int f = 0; f < 3; f++) begin
            frame(4'b0001, 0, 1'b0);
            n_checks++;
            if (bus.gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL single_gnt f%0d: got %b required 0001", f, bus.gnt);
            end
            n_checks++;
            if (bus.switched !== (f == 0)) begin
                n_fail++;
                $display("FAIL single_switched f%0d: got %b required %b", f, bus.switched,
                         f == 0);
            end
        end
        frame(4'b0001, 0, 1'b0);
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL single_pixels: %0d bad pixel cycles, required 0", pix_bad);
        end
        n_checks++;
        if (sw_bad !== 0) begin
            n_fail++;
            $display("FAIL single_stray_switched: %0d stray pulses, required 0", sw_bad);
        end
    endtask

    task automatic test_auto_rotate();
        logic [3:0] exp_g  [10];
        bit         exp_sw [10];
        exp_g  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                   4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        exp_sw = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        sw_bad = 0;
        for (int f = 0; f < 10; f++) begin
            frame(4'b0011, 0, 1'b0);
            n_checks++;
            if (bus.gnt !== exp_g[f] || bus.switched !== exp_sw[f]) begin
                n_fail++;
                $display("FAIL auto_rotate f%0d: got gnt=%b sw=%b required gnt=%b sw=%b",
                         f, bus.gnt, bus.switched, exp_g[f], exp_sw[f]);
            end
        end
        n_checks++;
        if (sw_bad !== 0) begin
            n_fail++;
            $display("FAIL auto_stray_switched: %0d stray pulses, required 0", sw_bad);
        end
    endtask

    task automatic test_drop_owner();
        // Owner is src1, granted one frame ago, so its dwell is not yet met.
        frame(4'b0101, 0, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b0100 || bus.switched !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_owner: got gnt=%b sw=%b required gnt=0100 sw=1",
                     bus.gnt, bus.switched);
        end
    endtask

    task automatic test_force();
        apply_reset();
        frame(4'b1001, 0, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL force_setup: got %b required 0001", bus.gnt);
        end
        frame(4'b1001, 2, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b1000 || bus.switched !== 1'b1) begin
            n_fail++;
            $display("FAIL force_on_tick: got gnt=%b sw=%b required gnt=1000 sw=1",
                     bus.gnt, bus.switched);
        end
        // Force with no other requester: owner kept, frame count restarted.
        apply_reset();
        for (int f = 0; f < 3; f++) frame(4'b0001, 0, 1'b0);
        frame(4'b0001, 2, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.switched !== 1'b0) begin
            n_fail++;
            $display("FAIL force_alone: got gnt=%b sw=%b required gnt=0001 sw=0",
                     bus.gnt, bus.switched);
        end
        // Restarted count means two more held frames before auto rotation.
        for (int f = 0; f < 3; f++) begin
            frame(4'b0011, 0, 1'b0);
            n_checks++;
            if (bus.gnt !== ((f == 2) ? 4'b0010 : 4'b0001)) begin
                n_fail++;
                $display("FAIL force_fcnt_restart f%0d: got %b required %b", f, bus.gnt,
                         (f == 2) ? 4'b0010 : 4'b0001);
            end
        end
        frame(4'b0011, 1, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.switched !== 1'b1) begin
            n_fail++;
            $display("FAIL force_mid_frame: got gnt=%b sw=%b required gnt=0001 sw=1",
                     bus.gnt, bus.switched);
        end
    endtask

    task automatic test_idle_release();
        pix_bad = 0;
        frame(4'b0000, 0, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.switched !== 1'b1) begin
            n_fail++;
            $display("FAIL release_idle: got gnt=%b sw=%b required gnt=0000 sw=1",
                     bus.gnt, bus.switched);
        end
        frame(4'b0000, 0, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.switched !== 1'b0) begin
            n_fail++;
            $display("FAIL stay_idle: got gnt=%b sw=%b required gnt=0000 sw=0",
                     bus.gnt, bus.switched);
        end
        frame(4'b1000, 0, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b1000 || bus.switched !== 1'b1) begin
            n_fail++;
            $display("FAIL regrant: got gnt=%b sw=%b required gnt=1000 sw=1",
                     bus.gnt, bus.switched);
        end
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL idle_pixels: %0d bad pixel cycles, required 0", pix_bad);
        end
    endtask

    task automatic test_reset_midframe();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({bus.r, bus.g, bus.b} !== exp_pix()) begin
                n_fail++;
                $display("FAIL midframe_pixel %0d: got %h required %h", i,
                         {bus.r, bus.g, bus.b}, exp_pix());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000 || {bus.r, bus.g, bus.b} !== 24'h0 || bus.switched !== 1'b0)
        begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b rgb=%h sw=%b required 0000/000000/0",
                     bus.gnt, {bus.r, bus.g, bus.b}, bus.switched);
        end
        model_reset();
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (bus.gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL no_grant_vd_low %0d: got %b required 0000", i, bus.gnt);
            end
        end
        frame(4'b1000, 0, 1'b0);
        n_checks++;
        if (bus.gnt !== 4'b1000 || bus.switched !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant_after_reset: got gnt=%b sw=%b required gnt=1000 sw=1",
                     bus.gnt, bus.switched);
        end
    endtask

    task automatic test_random();
        logic [3:0] rq;
        int         frc;
        apply_reset();
        pix_bad = 0;
        sw_bad  = 0;
        rq      = 4'b0110;
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 2) == 0) rq = 4'($urandom);
            frc = 0;
            if ($urandom_range(0, 7) == 0) frc = 1;
            else if ($urandom_range(0, 7) == 0) frc = 2;
            frame(rq, frc, 1'($urandom_range(0, 1)));
            n_checks++;
            if (bus.gnt !== oh(m_owner) || bus.switched !== m_sw) begin
                n_fail++;
                $display("FAIL random f%0d req=%b: got gnt=%b sw=%b required gnt=%b sw=%b",
                         f, rq, bus.gnt, bus.switched, oh(m_owner), m_sw);
            end
        end
        n_checks++;
        if (pix_bad !== 0) begin
            n_fail++;
            $display("FAIL random_pixels: %0d bad pixel cycles, required 0", pix_bad);
        end
        n_checks++;
        if (sw_bad !== 0) begin
            n_fail++;
            $display("FAIL random_stray_switched: %0d stray pulses, required 0", sw_bad);
        end
    endtask

    initial begin
        bus.vd         = 1'b1;
        bus.den        = 1'b0;
        bus.req        = '0;
        bus.force_next = 1'b0;
        bus.src_rgb    = '0;
        pix_bad        = 0;
        sw_bad         = 0;
        model_reset();
        test_reset();
        test_single_source();
        test_auto_rotate();
        test_drop_owner();
        test_force();
        test_idle_release();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

endmodule
